// File: rtl/redmule_pkg.sv
// Shared definitions for the RedMulE MX exponent aligner slice.
package redmule_pkg;

  // One 64-byte E8M0 exponent beat.
  localparam int unsigned EXP_BEAT_W = 512;

  // Aligner job FSM.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } aligner_state_e;

endpackage

// File: rtl/redmule_exp_fifo.sv
// DEPTH x W register FIFO holding exponent beats until their data beats
// have consumed them. The head is read combinationally from the register
// array, so a pushed beat becomes visible at the head one cycle later.
module redmule_exp_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 512
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  // Overflow and underflow are silently blocked; flush wins over both.
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  assign full  = (count == CNT_MAX);
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage array; no reset needed because entries are only read once written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/redmule_mx_exp_aligner.sv
// Pairs each X/W data beat with the E8M0 exponent beat that scales it.
// Exponent beats queue in a small FIFO; the head is shared by EXP_REUSE
// consecutive data beats and then released. Outside MX mode the block is a
// zero-latency pass-through for data.
//
// Handshakes: every port pair is valid/ready. A beat transfers on a rising
// edge where valid and ready are both high; a source holds valid and the
// payload stable until that edge. This block never retracts out_valid_o
// once raised, since it only falls on the accepting edge.
module redmule_mx_exp_aligner
  import redmule_pkg::*;
#(
  parameter int unsigned DW         = 256,
  parameter int unsigned EXPW       = EXP_BEAT_W,
  parameter int unsigned EXP_REUSE  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            mx_enable_i,
  input  logic            start_i,
  input  logic [31:0]     tot_len_i,
  input  logic            data_valid_i,
  output logic            data_ready_o,
  input  logic [DW-1:0]   data_i,
  input  logic            exp_valid_i,
  output logic            exp_ready_o,
  input  logic [EXPW-1:0] exp_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [DW-1:0]   out_data_o,
  output logic [EXPW-1:0] out_exp_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output aligner_state_e  state_o
);

  localparam int unsigned   RW         = $clog2(EXP_REUSE) + 1;
  localparam logic [RW-1:0] REUSE_LAST = RW'(EXP_REUSE - 1);
  localparam logic [RW-1:0] REUSE_ONE  = RW'(1);

  aligner_state_e  state_q;
  aligner_state_e  state_d;

  logic            mx_q;
  logic [31:0]     tot_q;
  logic [31:0]     beat_cnt_q;
  logic [RW-1:0]   reuse_cnt_q;
  logic            err_q;

  logic            start_ok;
  logic            fire;
  logic            last_beat;
  logic            push;
  logic            pop;
  logic            flush;
  logic            fifo_full;
  logic            fifo_empty;
  logic [EXPW-1:0] fifo_head;

  // A start is only honoured from IDLE; clear_i takes priority over it.
  assign start_ok  = (state_q == IDLE) & start_i & ~clear_i;
  assign fire      = out_valid_o & out_ready_i;
  assign last_beat = fire & (beat_cnt_q == (tot_q - 32'd1));

  // The head is released after EXP_REUSE uses, or early on the job's last beat.
  assign pop   = fire & mx_q & ((reuse_cnt_q == REUSE_LAST) | last_beat);
  assign push  = exp_valid_i & exp_ready_o;
  // Anything left in the FIFO at the end of a job is stale for the next one.
  assign flush = clear_i | (state_q == DONE);

  // Exponents may start arriving in the very cycle the job starts, before mx_q is loaded.
  assign exp_ready_o = ~fifo_full & ~clear_i &
                       (((state_q == RUN) & mx_q) | (start_ok & mx_enable_i));

  assign err_o   = err_q;
  assign state_o = state_q;

  redmule_exp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EXPW)
  ) u_exp_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .flush (flush),
    .push  (push),
    .wdata (exp_i),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // FSM state register; clear_i drops the job immediately without a done pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else if (clear_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: an empty job goes straight to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = (tot_len_i == 32'd0) ? DONE : RUN;
      end
      RUN: begin
        if (last_beat) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM outputs and handshake muxing; data and exponent paths are combinational.
  always_comb begin
    out_valid_o  = 1'b0;
    data_ready_o = 1'b0;
    out_data_o   = '0;
    out_exp_o    = '0;
    busy_o       = (state_q != IDLE);
    done_o       = (state_q == DONE);
    if (state_q == RUN) begin
      out_data_o = data_i;
      if (mx_q) begin
        out_valid_o  = data_valid_i & ~fifo_empty;
        data_ready_o = out_ready_i & ~fifo_empty;
        out_exp_o    = fifo_head;
      end else begin
        out_valid_o  = data_valid_i;
        data_ready_o = out_ready_i;
      end
    end
  end

  // Job registers: mode and length latched at start, beat/reuse counters, sticky error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mx_q        <= 1'b0;
      tot_q       <= '0;
      beat_cnt_q  <= '0;
      reuse_cnt_q <= '0;
      err_q       <= 1'b0;
    end else if (clear_i) begin
      mx_q        <= 1'b0;
      tot_q       <= '0;
      beat_cnt_q  <= '0;
      reuse_cnt_q <= '0;
      err_q       <= 1'b0;
    end else if (start_ok) begin
      mx_q        <= mx_enable_i;
      tot_q       <= tot_len_i;
      beat_cnt_q  <= '0;
      reuse_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      if (fire) beat_cnt_q <= beat_cnt_q + 32'd1;
      if (pop) begin
        reuse_cnt_q <= '0;
      end else if (fire && mx_q) begin
        reuse_cnt_q <= reuse_cnt_q + REUSE_ONE;
      end
      // Leftover or still-offered exponents mean the two streams disagreed on length.
      if ((state_q == DONE) && mx_q && (!fifo_empty || exp_valid_i)) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_redmule_mx_exp_aligner.sv
// Directed bench for redmule_mx_exp_aligner. Two instances share all
// stimulus: u_r1 uses EXP_REUSE=1, u_r2 uses EXP_REUSE=2. start_i is
// steered to the selected instance only, so the other stays idle.
module tb_redmule_mx_exp_aligner;
  import redmule_pkg::*;

  localparam int DW    = 16;
  localparam int EW    = 16;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic          sel;
  logic          clear;
  logic          mx_enable;
  logic          start;
  logic [31:0]   tot_len;
  logic          data_valid;
  logic [DW-1:0] data;
  logic          exp_valid;
  logic [EW-1:0] exp_beat;
  logic          out_ready;

  // ---------------- per-instance outputs ----------------
  logic a_data_ready, a_exp_ready, a_out_valid, a_busy, a_done, a_err;
  logic [DW-1:0] a_out_data;
  logic [EW-1:0] a_out_exp;
  aligner_state_e a_state;
  logic b_data_ready, b_exp_ready, b_out_valid, b_busy, b_done, b_err;
  logic [DW-1:0] b_out_data;
  logic [EW-1:0] b_out_exp;
  aligner_state_e b_state;

  // ---------------- selected view ----------------
  logic data_ready, exp_ready, out_valid, busy, done, err;
  logic [DW-1:0] out_data;
  logic [EW-1:0] out_exp;
  aligner_state_e state;

  always_comb begin
    if (sel) begin
      data_ready = b_data_ready; exp_ready = b_exp_ready; out_valid = b_out_valid;
      busy = b_busy; done = b_done; err = b_err; out_data = b_out_data;
      out_exp = b_out_exp; state = b_state;
    end else begin
      data_ready = a_data_ready; exp_ready = a_exp_ready; out_valid = a_out_valid;
      busy = a_busy; done = a_done; err = a_err; out_data = a_out_data;
      out_exp = a_out_exp; state = a_state;
    end
  end

  redmule_mx_exp_aligner #(.DW(DW), .EXPW(EW), .EXP_REUSE(1), .FIFO_DEPTH(DEPTH)) u_r1 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .mx_enable_i(mx_enable),
    .start_i(start & ~sel), .tot_len_i(tot_len),
    .data_valid_i(data_valid), .data_ready_o(a_data_ready), .data_i(data),
    .exp_valid_i(exp_valid), .exp_ready_o(a_exp_ready), .exp_i(exp_beat),
    .out_valid_o(a_out_valid), .out_ready_i(out_ready), .out_data_o(a_out_data),
    .out_exp_o(a_out_exp), .busy_o(a_busy), .done_o(a_done), .err_o(a_err),
    .state_o(a_state)
  );

  redmule_mx_exp_aligner #(.DW(DW), .EXPW(EW), .EXP_REUSE(2), .FIFO_DEPTH(DEPTH)) u_r2 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .mx_enable_i(mx_enable),
    .start_i(start & sel), .tot_len_i(tot_len),
    .data_valid_i(data_valid), .data_ready_o(b_data_ready), .data_i(data),
    .exp_valid_i(exp_valid), .exp_ready_o(b_exp_ready), .exp_i(exp_beat),
    .out_valid_o(b_out_valid), .out_ready_i(out_ready), .out_data_o(b_out_data),
    .out_exp_o(b_out_exp), .busy_o(b_busy), .done_o(b_done), .err_o(b_err),
    .state_o(b_state)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q[$];
  logic [EW-1:0] exp_scale_q[$];

  function automatic logic [EW-1:0] scale_of(input logic [DW-1:0] base, input int j);
    return 16'hC000 + base + EW'(j);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic mx, input logic [31:0] len);
    @(posedge clk); #1;
    mx_enable = mx; tot_len = len; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mx_enable = 1'b0; tot_len = 32'd0;
  endtask

  // Runs one job on the selected instance and checks every cycle against a
  // small occupancy model plus the expected (data, exponent) queue.
  task automatic run_job(input string name, input logic s, input logic mx, input int len,
                         input int n_exp, input int exp_delay, input bit rand_rdy,
                         input bit bursty, input logic [DW-1:0] dbase, input bit want_full);
    int reuse, needed, di, ei, acc, occ, cyc, last_acc;
    bit done_seen, full_seen, err_exp, pop_m, push_m, ev_pending, model_run;
    logic want_v, want_r, want_e;
    logic [DW-1:0] wd;
    logic [EW-1:0] we;
    reuse   = s ? 2 : 1;
    needed  = (len + reuse - 1) / reuse;
    err_exp = mx && (n_exp > needed);
    exp_q.delete();
    exp_scale_q.delete();
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(dbase + DW'(i));
      exp_scale_q.push_back(mx ? scale_of(dbase, i / reuse) : '0);
    end
    sel = s; data_valid = 1'b0; exp_valid = 1'b0; out_ready = 1'b0;
    do_start(mx, len);
    di = 0; ei = 0; acc = 0; occ = 0; cyc = 0; last_acc = -10;
    done_seen = 0; full_seen = 0; ev_pending = 0;
    while (!done_seen && cyc < 400) begin
      model_run  = (acc < len);
      data_valid = (di < len);
      data       = dbase + DW'(di);
      if (!ev_pending)
        ev_pending = (ei < n_exp) && (cyc >= exp_delay) && (!bursty || (cyc % 4) < 2);
      exp_valid  = ev_pending;
      exp_beat   = scale_of(dbase, ei);
      out_ready  = rand_rdy ? ((cyc >= 6) && ($urandom_range(0, 1) == 1)) : 1'b1;
      #4;
      if (cyc == 0) begin
        checks++;
        if (err !== 1'b0) begin
          errors++; $display("FAIL %s err_after_start: got %b want 0", name, err);
        end
      end
      if (model_run) begin
        want_v = mx ? (data_valid && occ > 0) : data_valid;
        want_r = mx ? (out_ready && occ > 0) : out_ready;
        want_e = mx && (occ < DEPTH);
        checks++;
        if (out_valid !== want_v) begin
          errors++; $display("FAIL %s out_valid cyc%0d: got %b want %b", name, cyc, out_valid, want_v);
        end
        checks++;
        if (data_ready !== want_r) begin
          errors++; $display("FAIL %s data_ready cyc%0d: got %b want %b", name, cyc, data_ready, want_r);
        end
        checks++;
        if (exp_ready !== want_e) begin
          errors++; $display("FAIL %s exp_ready cyc%0d: got %b want %b", name, cyc, exp_ready, want_e);
        end
        if (mx && occ == DEPTH) full_seen = 1;
      end
      pop_m = 0;
      if (model_run && out_valid === 1'b1 && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL %s extra_beat: got %h want none", name, out_data);
        end else begin
          wd = exp_q.pop_front();
          we = exp_scale_q.pop_front();
          if (out_data !== wd || out_exp !== we) begin
            errors++;
            $display("FAIL %s beat%0d: got data %h exp %h want data %h exp %h", name, acc, out_data, out_exp, wd, we);
          end
        end
        acc++; di++; last_acc = cyc;
        pop_m = mx && ((acc % reuse) == 0 || acc == len);
      end
      push_m = exp_valid && (exp_ready === 1'b1);
      if (push_m) begin
        ei++; ev_pending = 0;
      end
      occ = occ + (push_m ? 1 : 0) - (pop_m ? 1 : 0);
      if (done === 1'b1) begin
        done_seen = 1;
        checks++;
        if (cyc != last_acc + 1) begin
          errors++; $display("FAIL %s done_timing: got cyc %0d want cyc %0d", name, cyc, last_acc + 1);
        end
        checks++;
        if (out_valid !== 1'b0) begin
          errors++; $display("FAIL %s out_valid_in_done: got %b want 0", name, out_valid);
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    exp_valid = 1'b0; data_valid = 1'b0;
    checks++;
    if (!done_seen) begin
      errors++; $display("FAIL %s done_timeout: got no done want done within 400 cycles", name);
    end
    checks++;
    if (acc != len) begin
      errors++; $display("FAIL %s beat_count: got %0d want %0d", name, acc, len);
    end
    if (want_full) begin
      checks++;
      if (!full_seen) begin
        errors++; $display("FAIL %s fifo_fill: got not full want full at least once", name);
      end
    end
    #3;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL %s idle_after_done: got busy %b done %b want 0 0", name, busy, done);
    end
    checks++;
    if (err !== err_exp) begin
      errors++; $display("FAIL %s err: got %b want %b", name, err, err_exp);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; start = 1'b0; sel = 1'b0;
    mx_enable = 1'b1; tot_len = 32'd4; data_valid = 1'b1; data = 16'h1234;
    exp_valid = 1'b1; exp_beat = 16'h5678; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #4;
    for (int k = 0; k < 2; k++) begin
      sel = (k == 1);
      #1;
      checks++;
      if ({out_valid, data_ready, exp_ready, busy, done, err} !== 6'b0) begin
        errors++;
        $display("FAIL reset_ctrl inst%0d: got v%b dr%b er%b b%b d%b e%b want all 0", k,
                 out_valid, data_ready, exp_ready, busy, done, err);
      end
      checks++;
      if (out_exp !== '0 || out_data !== '0) begin
        errors++; $display("FAIL reset_payload inst%0d: got %h %h want 0 0", k, out_data, out_exp);
      end
      checks++;
      if (state !== IDLE) begin
        errors++; $display("FAIL reset_state inst%0d: got %0d want IDLE", k, state);
      end
    end
    sel = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #4;
    checks++;
    if (data_ready !== 1'b0 || out_valid !== 1'b0 || exp_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_start: got dr%b v%b er%b want 0 0 0", data_ready, out_valid, exp_ready);
    end
    #1;
    mx_enable = 1'b0; tot_len = 32'd0; data_valid = 1'b0; data = '0;
    exp_valid = 1'b0; exp_beat = '0; out_ready = 1'b0;
  endtask

  task automatic test_passthrough();
    run_job("nonmx", 1'b0, 1'b0, 8, 2, 0, 1'b0, 1'b0, 16'h0100, 1'b0);
  endtask

  task automatic test_mx_reuse1();
    run_job("mx_r1", 1'b0, 1'b1, 4, 4, 3, 1'b0, 1'b0, 16'h0200, 1'b0);
  endtask

  task automatic test_mx_reuse2();
    run_job("mx_r2", 1'b1, 1'b1, 6, 3, 0, 1'b0, 1'b0, 16'h0300, 1'b0);
    run_job("mx_r2_partial", 1'b1, 1'b1, 5, 3, 1, 1'b0, 1'b0, 16'h0380, 1'b0);
  endtask

  task automatic test_backpressure();
    run_job("backpressure", 1'b0, 1'b1, 12, 12, 0, 1'b1, 1'b1, 16'h0400, 1'b1);
  endtask

  task automatic test_mismatch();
    run_job("mismatch", 1'b0, 1'b1, 2, 3, 0, 1'b0, 1'b0, 16'h0500, 1'b0);
    repeat (3) @(posedge clk);
    #4;
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL mismatch_sticky: got %b want 1", err);
    end
    // The flushed FIFO shows up as out_valid staying low until the new exponent lands.
    run_job("after_flush", 1'b0, 1'b1, 1, 1, 3, 1'b0, 1'b0, 16'h0580, 1'b0);
  endtask

  task automatic test_clear();
    sel = 1'b0;
    do_start(1'b0, 32'd5);
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      data_valid = 1'b1; data = 16'h0600 + DW'(i);
      #4;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'h0600 + DW'(i)) begin
        errors++; $display("FAIL clear_pre_beat%0d: got v%b %h want v1 %h", i, out_valid, out_data, 16'h0600 + DW'(i));
      end
      @(posedge clk); #1;
    end
    clear = 1'b1; data = 16'h0602;
    @(posedge clk); #1;
    clear = 1'b0; data_valid = 1'b0;
    #3;
    checks++;
    if (busy !== 1'b0 || state !== IDLE) begin
      errors++; $display("FAIL clear_idle: got busy %b state %0d want 0 IDLE", busy, state);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (done !== 1'b0 || err !== 1'b0) begin
        errors++; $display("FAIL clear_no_done cyc%0d: got done %b err %b want 0 0", i, done, err);
      end
      @(posedge clk); #4;
    end
    run_job("clear_restart", 1'b0, 1'b0, 3, 0, 0, 1'b0, 1'b0, 16'h0700, 1'b0);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_passthrough();
    test_mx_reuse1();
    test_mx_reuse2();
    test_backpressure();
    test_mismatch();
    test_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
